param_datapath: RTL

- Parametrised successor to the 8-bit processor datapath; holds IR, PC, accumulator A, output register, unified instruction/data RAM, and a multi-op ALU.
- All control strobes come from the external control-unit FSM.
- Generalised in data width and RAM depth; adds AND/OR ALU ops, a registered output port, and optional carry/overflow flags.
- Exposes opcode and status bits back to the FSM.

---
 rtl/param_datapath.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/param_datapath.sv
// Parametrised accumulator datapath: IR, PC, A, output register, unified RAM and a 4-op ALU.
// Optional carry/overflow flags are built only when DP_FLAGS_EN is defined.
module param_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              IRload,
    input  logic              JMPmux,
    input  logic              PCload,
    input  logic              Meminst,
    input  logic              MemWr,
    input  logic [1:0]        Asel,
    input  logic              Aload,
    input  logic [1:0]        ALUop,
    input  logic              Outload,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic [2:0]        IR_op,
    output logic [ADDR_W-1:0] IR_addr,
    output logic              Aeq0,
    output logic              Apos,
    output logic              Cflag,
    output logic              Vflag,
    output logic [DATA_W-1:0] regAOut,
    output logic [DATA_W-1:0] RAMout
);

    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] add_res;
    logic [DATA_W-1:0] alu_res;

    assign mem_addr = Meminst ? ir_q[ADDR_W-1:0] : pc_q;
    assign RAMout   = mem_q[mem_addr];

    // Subtract is A + ~M + 1; the +1 comes from ALUop[0].
    assign b_op = (ALUop == 2'd1) ? ~RAMout : RAMout;

`ifdef DP_FLAGS_EN
    logic [DATA_W:0] sum_ext;
    logic            alu_c, alu_v;
    logic            c_q, c_d, v_q, v_d;

    assign sum_ext = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, ALUop[0]};
    assign add_res = sum_ext[DATA_W-1:0];
    assign alu_c   = ~ALUop[1] & sum_ext[DATA_W];
    assign alu_v   = ~ALUop[1] & (a_q[DATA_W-1] == b_op[DATA_W-1])
                   & (add_res[DATA_W-1] != a_q[DATA_W-1]);

    always_comb begin
        c_d = c_q;
        v_d = v_q;
        if (Aload && (Asel == 2'd0)) begin
            c_d = alu_c;
            v_d = alu_v;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign Cflag = c_q;
    assign Vflag = v_q;
`else
    assign add_res = a_q + b_op + {{(DATA_W-1){1'b0}}, ALUop[0]};
    assign Cflag   = 1'b0;
    assign Vflag   = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        unique case (ALUop)
            2'd0, 2'd1: alu_res = add_res;
            2'd2:       alu_res = a_q & RAMout;
            2'd3:       alu_res = a_q | RAMout;
            default:    alu_res = '0;
        endcase
    end

    always_comb begin
        ir_d  = ir_q;
        pc_d  = pc_q;
        a_d   = a_q;
        out_d = out_q;
        if (IRload) ir_d = RAMout;
        if (PCload) pc_d = JMPmux ? ir_q[ADDR_W-1:0] : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (Aload) begin
            unique case (Asel)
                2'd0:    a_d = alu_res;
                2'd1:    a_d = in;
                2'd2:    a_d = RAMout;
                2'd3:    a_d = '0;
                default: a_d = '0;
            endcase
        end
        if (Outload) out_d = a_q;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ir_q  <= '0;
            pc_q  <= '0;
            a_q   <= '0;
            out_q <= '0;
        end else begin
            ir_q  <= ir_d;
            pc_q  <= pc_d;
            a_q   <= a_d;
            out_q <= out_d;
        end
    end

    // RAM contents survive clear; a write coinciding with clear is dropped.
    always_ff @(posedge clk) begin
        if (!clear && MemWr) mem_q[mem_addr] <= a_q;
    end

    assign out     = out_q;
    assign IR_op   = ir_q[DATA_W-1:DATA_W-3];
    assign IR_addr = ir_q[ADDR_W-1:0];
    assign regAOut = a_q;
    assign Aeq0    = (a_q == '0);
    assign Apos    = ~a_q[DATA_W-1] & (a_q != '0);

endmodule
